// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate format encodings, slice states and shared sign-extension helper
package imm_gen_pkg;

    typedef enum logic [2:0] {
        SEL_I,
        SEL_S,
        SEL_B,
        SEL_J,
        SEL_U,
        SEL_Z,
        SEL_SH,
        SEL_RSVD
    } imm_sel_e;

    typedef enum logic [1:0] {
        SLICE_EMPTY,
        SLICE_ONE,
        SLICE_TWO
    } slice_state_e;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    // Widen a 32-bit two's-complement value to the largest supported XLEN
    function automatic logic [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational instruction + format select -> XLEN immediate and illegal flag
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = XLEN_32
) (
    input  logic [31:0]     instr,
    input  imm_sel_e        sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] raw;
    logic        signed_fmt;
    logic        unused_opcode;

    // The opcode field never contributes to any immediate
    assign unused_opcode = ^instr[6:0];

    // Assemble every format as a 32-bit value; widening to XLEN happens afterwards
    always_comb begin
        raw = '0;
        case (sel)
            SEL_I:   raw = {{20{instr[31]}}, instr[31:20]};
            SEL_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SEL_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            SEL_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            SEL_U:   raw = {instr[31:12], 12'b0};
            SEL_Z:   raw = {27'b0, instr[19:15]};
            SEL_SH:  raw = (XLEN == XLEN_64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            default: raw = '0;
        endcase
    end

    assign signed_fmt = sel inside {SEL_I, SEL_S, SEL_B, SEL_J, SEL_U};
    assign illegal    = sel == SEL_RSVD;
    assign imm        = XLEN'(signed_fmt ? sext(raw) : {32'b0, raw});

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready slice, tag side-band and illegal counter
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [15:0]      illegal_cnt
);

    localparam int EW = XLEN + TAG_W + 1;

    if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic [EW-1:0]   in_ent;
    logic [EW-1:0]   main_q;
    logic            in_fire;
    logic            out_fire;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .sel     (imm_sel_e'(in_sel)),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign in_ent                            = {dec_ill, in_tag, dec_imm};
    assign {out_illegal, out_tag, out_imm}   = main_q;
    assign in_fire                           = in_valid & in_ready;
    assign out_fire                          = out_valid & out_ready;

    if (SKID != 0) begin : g_skid
        slice_state_e  state;
        logic [EW-1:0] skid_q;
        assign in_ready  = state != SLICE_TWO;
        assign out_valid = state != SLICE_EMPTY;
        // Two-entry slice: main drives the outputs, skid catches one extra word while stalled
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= SLICE_EMPTY;
                main_q <= '0;
                skid_q <= '0;
            end else begin
                case (state)
                    SLICE_EMPTY: if (in_fire) begin
                        main_q <= in_ent;
                        state  <= SLICE_ONE;
                    end
                    SLICE_ONE: if (in_fire && !out_fire) begin
                        skid_q <= in_ent;
                        state  <= SLICE_TWO;
                    end else if (out_fire && !in_fire) begin
                        state  <= SLICE_EMPTY;
                    end else if (in_fire) begin
                        main_q <= in_ent;
                    end
                    SLICE_TWO: if (out_fire) begin
                        main_q <= skid_q;
                        state  <= SLICE_ONE;
                    end
                    default: state <= SLICE_EMPTY;
                endcase
            end
        end
    end else begin : g_single
        logic valid_q;
        assign in_ready  = !valid_q | out_ready;
        assign out_valid = valid_q;
        // Single-entry slice: a new word may replace the one leaving on the same edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
                main_q  <= in_ent;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Count reserved selects as they are accepted, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (in_fire && dec_ill && illegal_cnt != 16'hFFFF) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table, directed slice/reset/counter sequences and a randomized scoreboard
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_sel = '0;
    logic [3:0]  in_tag = '0;

    logic        ir [2];
    logic        ov [2];
    logic        oill [2];
    logic [3:0]  otag [2];
    logic [15:0] cnt [2];
    logic [31:0] oimm32;
    logic [63:0] oimm64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4), .SKID(1)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .out_imm(oimm32),
        .out_tag(otag[0]), .out_illegal(oill[0]), .illegal_cnt(cnt[0])
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4), .SKID(0)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready), .out_imm(oimm64),
        .out_tag(otag[1]), .out_illegal(oill[1]), .illegal_cnt(cnt[1])
    );

    task automatic chk(string nm, int d, logic [68:0] act, logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, d, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] imm_of(int d);
        return d != 0 ? oimm64 : {32'b0, oimm32};
    endfunction

    // Reference: immediates as signed integers built from the field values
    function automatic logic [64:0] model(logic [31:0] i, logic [2:0] sel, int xlen);
        longint      v;
        logic [63:0] r;
        longint      s = longint'($signed(i));
        case (sel)
            3'd0: v = s >>> 20;
            3'd1: v = (s >>> 25) * 32 + longint'(i[11:7]);
            3'd2: v = (s >>> 31) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                      + longint'(i[11:8]) * 2;
            3'd3: v = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                      + longint'(i[30:21]) * 2;
            3'd4: v = (s >>> 12) * 4096;
            3'd5: v = longint'(i[19:15]);
            3'd6: v = xlen == 64 ? longint'(i[25:20]) : longint'(i[24:20]);
            default: v = 0;
        endcase
        r = 64'(v);
        if (xlen == 32) r[63:32] = '0;
        return {sel == 3'd7, r};
    endfunction

    logic [68:0] exq [2][$];
    int          cm [2];
    logic        pv [2];
    logic [68:0] pout [2];
    logic [68:0] cur;
    logic [64:0] m;

    // Scoreboard: inputs are stable from just after posedge, so each negedge sees the next edge's handshakes
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                exq[d].delete();
                cm[d] = 0;
                pv[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                cur = {oill[d], otag[d], imm_of(d)};
                if (pv[d]) chk("hold", d, cur, pout[d]);
                chk("illegal_cnt", d, 69'(cnt[d]), 69'(cm[d]));
                if (ov[d] && out_ready) begin
                    chk("has_expected", d, 69'(exq[d].size() != 0), 69'(1));
                    if (exq[d].size() != 0) chk("data", d, cur, exq[d].pop_front());
                end
                if (in_valid && ir[d]) begin
                    m = model(in_instr, in_sel, d != 0 ? 64 : 32);
                    exq[d].push_back({m[64], in_tag, m[63:0]});
                    if (m[64] && cm[d] < 65535) cm[d]++;
                end
                pv[d]   = ov[d] && !out_ready;
                pout[d] = cur;
            end
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;

    vec_t vec [9];

    initial begin
        vec[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vec[1] = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000_000007FF, 1'b0};
        vec[2] = '{32'hFE000C23, 3'd1, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0};
        vec[3] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vec[4] = '{32'h0080006F, 3'd3, 32'h00000008, 64'h00000000_00000008, 1'b0};
        vec[5] = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0};
        vec[6] = '{32'h03F0D093, 3'd5, 32'h00000001, 64'h00000000_00000001, 1'b0};
        vec[7] = '{32'h03F0D093, 3'd6, 32'h0000001F, 64'h00000000_0000003F, 1'b0};
        vec[8] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h00000000_00000000, 1'b1};

        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, 69'(ov[d]), 69'(0));
            chk("rst_imm", d, 69'(imm_of(d)), 69'(0));
            chk("rst_tag", d, 69'(otag[d]), 69'(0));
            chk("rst_illegal", d, 69'(oill[d]), 69'(0));
            chk("rst_cnt", d, 69'(cnt[d]), 69'(0));
        end
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 0, 69'(ir[0]), 69'(1));

        tick;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_instr = vec[k].instr;
            in_sel   = vec[k].sel;
            in_tag   = 4'(k);
            tick;
            in_valid = 1'b0;
            @(negedge clk);
            chk("vec_valid32", k, 69'(ov[0]), 69'(1));
            chk("vec_valid64", k, 69'(ov[1]), 69'(1));
            chk("vec_imm32", k, 69'(oimm32), 69'(vec[k].e32));
            chk("vec_imm64", k, 69'(oimm64), 69'(vec[k].e64));
            chk("vec_ill32", k, 69'(oill[0]), 69'(vec[k].ill));
            chk("vec_ill64", k, 69'(oill[1]), 69'(vec[k].ill));
            tick;
        end

        for (int n = 0; n < 1500; n++) begin
            in_valid  = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < 6;
            in_instr  = $urandom;
            in_sel    = 3'($urandom_range(0, 7));
            in_tag    = 4'($urandom);
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick;

        in_sel    = 3'd0;
        in_instr  = 32'h00100093;
        in_valid  = 1'b1;
        in_tag    = 4'd1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("a_ready_empty", 0, 69'(ir[0]), 69'(1));
        tick;
        in_tag = 4'd2;
        @(negedge clk);
        chk("a_latency", 0, 69'(ov[0]), 69'(1));
        chk("a_tag1_early", 0, 69'(otag[0]), 69'(1));
        chk("a_ready_one", 0, 69'(ir[0]), 69'(1));
        tick;
        in_tag = 4'd3;
        @(negedge clk);
        chk("a_ready_full", 0, 69'(ir[0]), 69'(0));
        tick;
        out_ready = 1'b1;
        @(negedge clk);
        chk("a_out1_valid", 0, 69'(ov[0]), 69'(1));
        chk("a_out1_tag", 0, 69'(otag[0]), 69'(1));
        chk("a_still_full", 0, 69'(ir[0]), 69'(0));
        tick;
        @(negedge clk);
        chk("a_out2_valid", 0, 69'(ov[0]), 69'(1));
        chk("a_out2_tag", 0, 69'(otag[0]), 69'(2));
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("a_out3_valid", 0, 69'(ov[0]), 69'(1));
        chk("a_out3_tag", 0, 69'(otag[0]), 69'(3));
        tick;
        @(negedge clk);
        chk("a_empty", 0, 69'(ov[0]), 69'(0));

        tick;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 4'd7;
        tick;
        tick;
        @(negedge clk);
        chk("c_two", 0, 69'(ir[0]), 69'(0));
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("c_rst_valid", d, 69'(ov[d]), 69'(0));
            chk("c_rst_cnt", d, 69'(cnt[d]), 69'(0));
            chk("c_rst_imm", d, 69'(imm_of(d)), 69'(0));
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("c_ready", 0, 69'(ir[0]), 69'(1));
        chk("c_idle", 0, 69'(ov[0]), 69'(0));
        tick;
        in_valid  = 1'b1;
        in_tag    = 4'd5;
        in_sel    = 3'd0;
        in_instr  = 32'hFFF00093;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("c_latency", d, 69'(ov[d]), 69'(1));
            chk("c_tag", d, 69'(otag[d]), 69'(5));
        end
        chk("c_imm32", 0, 69'(oimm32), 69'(32'hFFFFFFFF));
        tick;

        in_valid = 1'b1;
        in_sel   = 3'd7;
        in_instr = $urandom;
        repeat (3) tick;
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("b_cnt3", d, 69'(cnt[d]), 69'(3));
            chk("b_illegal", d, 69'(oill[d]), 69'(1));
            chk("b_imm", d, 69'(imm_of(d)), 69'(0));
        end
        tick;
        in_valid = 1'b1;
        repeat (65538) tick;
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("b_saturate", d, 69'(cnt[d]), 69'(16'hFFFF));
        repeat (4) tick;
        for (int d = 0; d < 2; d++) chk("drained", d, 69'(exq[d].size()), 69'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
